// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the byte-wide RAM controller.
//   state_e        - controller FSM states
//   MEM_SIZE_B/H/W - mem_size encodings (3 is reserved and treated as word)
//   size_to_n()    - access size to byte count (1/2/4)
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_e;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: return 3'd1;
            MEM_SIZE_H: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_assemble.sv
// mem_ctrl_assemble: collects read bytes into a little-endian word and
// extends the result for sub-word loads.
//   clk, rst   - clock, asynchronous active-low reset
//   clear      - empty the lane register (start of a transfer)
//   load       - capture din into lane byte_idx this cycle
//   byte_idx   - lane receiving din
//   din        - read byte from the RAM
//   size       - access size (MEM_SIZE_*), sign_en - sign-extend
//   word_next  - lanes including the byte arriving this cycle (raw)
//   ext_next   - word_next zero/sign-extended according to size
module mem_ctrl_assemble
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [1:0]  byte_idx,
    input  logic [7:0]  din,
    input  logic [1:0]  size,
    input  logic        sign_en,
    output logic [31:0] word_next,
    output logic [31:0] ext_next
);

    logic [31:0] acc_q, acc_d;

    // word_next already contains the byte being sampled, so the final byte
    // can be delivered on the same edge that captures it.
    always_comb begin
        word_next = acc_q;
        word_next[8*byte_idx +: 8] = din;

        acc_d = acc_q;
        if (clear)
            acc_d = '0;
        else if (load)
            acc_d = word_next;

        case (size)
            MEM_SIZE_B: ext_next = {{24{sign_en & word_next[7]}},  word_next[7:0]};
            MEM_SIZE_H: ext_next = {{16{sign_en & word_next[15]}}, word_next[15:0]};
            default:    ext_next = word_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide RAM controller / arbiter shared by the
// instruction fetch path and the MEM stage. Each 1/2/4-byte access is
// serialised into byte transfers; MEM has priority, no preemption.
//   clk, rst                    - clock, asynchronous active-low reset
//   if_req/if_addr/if_flush     - fetch request (always a word)
//   if_done/if_data             - fetch completion pulse and instruction
//   mem_req/we/size/signed/addr/wdata - load/store request
//   mem_done/mem_rdata          - completion pulse and extended load data
//   ram_addr/ram_wr/ram_dout/ram_din  - external byte RAM port
//   busy                        - transfer in progress
// Optional: define MEM_CTRL_FETCH_ABORT_EN to let if_flush abort a fetch.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;     // cycles spent in the current transfer
    logic [2:0]        n_q, n_d;         // bytes in the current transfer
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              asm_clear, asm_load;
    logic [31:0]       word_next, ext_next;
    logic [2:0]        cnt_nxt;
    logic              if_ok, mem_ok;

    assign cnt_nxt = cnt_q + 3'd1;

    // A requester is ineligible on the edge ending its own done cycle, since
    // its req is still high while it observes the done pulse.
    assign mem_ok = mem_req && !mem_done_q;
`ifdef MEM_CTRL_FETCH_ABORT_EN
    assign if_ok  = if_req && !if_done_q && !if_flush;
`else
    assign if_ok  = if_req && !if_done_q;
    logic unused_flush;
    assign unused_flush = if_flush;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        asm_clear   = 1'b0;
        asm_load    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_ok) begin
                    base_d     = mem_addr;
                    n_d        = size_to_n(mem_size);
                    size_d     = mem_size;
                    signed_d   = mem_signed;
                    wdata_d    = mem_wdata;
                    ram_addr_d = mem_addr;
                    asm_clear  = 1'b1;
                    if (mem_we) begin
                        state_d    = MEM_WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d    = MEM_RD;
                    end
                end else if (if_ok) begin
                    base_d     = if_addr;
                    n_d        = 3'd4;
                    size_d     = MEM_SIZE_W;
                    signed_d   = 1'b0;
                    ram_addr_d = if_addr;
                    asm_clear  = 1'b1;
                    state_d    = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                // Address phase runs for cnt < n; data lags by one cycle,
                // so the byte on ram_din while cnt = c belongs to lane c-1.
                cnt_d = cnt_nxt;
                if (cnt_nxt < n_q)
                    ram_addr_d = base_q + ADDR_W'(cnt_nxt);
                if (cnt_q != 3'd0)
                    asm_load = 1'b1;
                if (cnt_q == n_q) begin
                    state_d = IDLE;
                    if (state_q == IF_RD) begin
                        if_done_d = 1'b1;
                        if_data_d = word_next;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = ext_next;
                    end
                end
            end
            MEM_WR: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt < n_q) begin
                    ram_addr_d = base_q + ADDR_W'(cnt_nxt);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = 8'(wdata_q >> {cnt_nxt, 3'b000});
                end else begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MEM_CTRL_FETCH_ABORT_EN
        // Aborted fetch: drop back to IDLE silently; the late RAM byte lands
        // in the lane register but is cleared by the next grant.
        if (state_q == IF_RD && if_flush) begin
            state_d   = IDLE;
            if_done_d = 1'b0;
            if_data_d = if_data_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            size_q      <= MEM_SIZE_W;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    mem_ctrl_assemble u_assemble (
        .clk      (clk),
        .rst      (rst),
        .clear    (asm_clear),
        .load     (asm_load),
        .byte_idx (cnt_q[1:0] - 2'd1),
        .din      (ram_din),
        .size     (size_q),
        .sign_en  (signed_q),
        .word_next(word_next),
        .ext_next (ext_next)
    );

    // Reads: busy only during the address phase; writes: every ram_wr cycle.
    assign busy = (state_q == MEM_WR) ||
                  (((state_q == IF_RD) || (state_q == MEM_RD)) && (cnt_q < n_q));

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A behavioural byte RAM
// answers the RAM port; a separate reference byte map predicts every load.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_signed = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
        .ram_din(ram_din), .busy(busy)
    );

    logic [7:0]  ram  [logic [31:0]];   // device contents
    logic [7:0]  refm [logic [31:0]];   // reference prediction
    logic [31:0] wl_addr[$];
    logic [7:0]  wl_data[$];
    logic [31:0] trace[$];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // External RAM: one-cycle registered read, write on ram_wr.
    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_addr] = ram_dout;
            wl_addr.push_back(ram_addr);
            wl_data.push_back(ram_dout);
        end
        ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : init_byte(ram_addr);
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_byte(a);
    endfunction

    // Little-endian value of n bytes, optionally two's-complement signed.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_rd(a + 32'(i))) << (8 * i));
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]  = b;
        refm[a] = b;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drives one request from idle, scrambles the request fields after the
    // grant edge, and returns the cycle of the done pulse relative to grant.
    task automatic run_access(input bit is_if, input bit we, input logic [1:0] sz,
                              input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                              output int lat, output logic [31:0] data, output int bcnt);
        bit done_seen;
        trace.delete(); wl_addr.delete(); wl_data.delete();
        if (is_if) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_size = sz; mem_signed = sgn;
            mem_addr = a; mem_wdata = wd;
        end
        tick();
        if_addr = $urandom(); mem_addr = $urandom(); mem_wdata = $urandom();
        mem_size = 2'($urandom_range(0, 3)); mem_signed = ~sgn;
        lat = 1; bcnt = 0; done_seen = 0;
        while (lat < 20 && !done_seen) begin
            if (busy) bcnt++;
            trace.push_back(ram_addr);
            if (is_if ? if_done : mem_done) done_seen = 1;
            else begin tick(); lat++; end
        end
        data = is_if ? if_data : mem_rdata;
        if_req = 1'b0; mem_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int lat, bcnt, pulses;
        logic [31:0] d;
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({ram_addr, ram_wr, ram_dout, if_done, mem_done, if_data, mem_rdata, busy} !== '0) begin
            failures++; $display("FAIL reset_values got nonzero outputs ram_addr=%h busy=%b", ram_addr, busy);
        end
        rst = 1'b1; tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_signed = 1'b0; mem_addr = 32'h0000_0500;
        tick(); tick();  // now in cycle E+2
        checks++;
        if (busy !== 1'b1 || ram_addr !== 32'h0000_0501) begin
            failures++; $display("FAIL reset_pre busy=%b ram_addr=%h required 1/00000501", busy, ram_addr);
        end
        rst = 1'b0; #1;
        checks++;
        if ({ram_addr, ram_wr, ram_dout, if_done, mem_done, if_data, mem_rdata, busy} !== '0) begin
            failures++; $display("FAIL reset_async ram_addr=%h busy=%b required all zero", ram_addr, busy);
        end
        mem_req = 1'b0;
        tick(); rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_done || if_done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("FAIL reset_no_done got %0d active cycles required 0", pulses);
        end
        run_access(0, 0, 2'd2, 0, 32'h0000_0500, '0, lat, d, bcnt);
        checks++;
        if (lat != 6 || d !== ref_load(32'h500, 4, 0)) begin
            failures++; $display("FAIL reset_after_read lat=%0d data=%h required 6/%h", lat, d, ref_load(32'h500, 4, 0));
        end
    endtask

    task automatic test_fetch();
        int lat, bcnt;
        logic [31:0] d;
        preload(32'h100, 8'h13); preload(32'h101, 8'h02);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        run_access(1, 0, 2'd2, 0, 32'h100, '0, lat, d, bcnt);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL fetch_latency got %0d required 6", lat); end
        checks++;
        if (d !== 32'h0000_0213) begin failures++; $display("FAIL fetch_data got %h required 00000213", d); end
        checks++;
        if (bcnt != 4) begin failures++; $display("FAIL fetch_busy got %0d required 4", bcnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (trace.size() <= i || trace[i] !== 32'h100 + 32'(i)) begin
                failures++; $display("FAIL fetch_addr byte %0d required %h", i, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_loads();
        int lat, bcnt;
        logic [31:0] d;
        preload(32'h300, 8'h80);
        preload(32'h310, 8'h01); preload(32'h311, 8'h80);
        preload(32'hFFFF_FFFF, 8'h34); preload(32'h0, 8'h12);
        run_access(0, 0, 2'd0, 1, 32'h300, '0, lat, d, bcnt);
        checks++;
        if (d !== 32'hFFFF_FF80 || lat != 3) begin failures++; $display("FAIL lb_signed got %h lat %0d required ffffff80 lat 3", d, lat); end
        run_access(0, 0, 2'd1, 0, 32'h310, '0, lat, d, bcnt);
        checks++;
        if (d !== 32'h0000_8001 || lat != 4) begin failures++; $display("FAIL lhu got %h lat %0d required 00008001 lat 4", d, lat); end
        run_access(0, 0, 2'd1, 1, 32'h310, '0, lat, d, bcnt);
        checks++;
        if (d !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_signed got %h required ffff8001", d); end
        run_access(0, 0, 2'd1, 0, 32'hFFFF_FFFF, '0, lat, d, bcnt);
        checks++;
        if (trace.size() < 2 || trace[0] !== 32'hFFFF_FFFF || trace[1] !== 32'h0) begin
            failures++; $display("FAIL wrap_addr trace did not go ffffffff then 00000000");
        end
        checks++;
        if (d !== 32'h0000_1234) begin failures++; $display("FAIL wrap_data got %h required 00001234", d); end
    endtask

    task automatic test_store();
        int lat, bcnt;
        logic [31:0] d;
        run_access(0, 1, 2'd1, 0, 32'h200, 32'h1234_ABCD, lat, d, bcnt);
        refm[32'h200] = 8'hCD; refm[32'h201] = 8'hAB;
        checks++;
        if (lat != 3) begin failures++; $display("FAIL sh_latency got %0d required 3", lat); end
        checks++;
        if (wl_addr.size() != 2 || bcnt != 2) begin
            failures++; $display("FAIL sh_wr_cycles got %0d busy %0d required 2", wl_addr.size(), bcnt);
        end else begin
            checks++;
            if (wl_addr[0] !== 32'h200 || wl_data[0] !== 8'hCD || wl_addr[1] !== 32'h201 || wl_data[1] !== 8'hAB) begin
                failures++; $display("FAIL sh_bytes got %h:%h %h:%h required 200:cd 201:ab", wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]);
            end
        end
        checks++;
        if (ram_wr !== 1'b0 || ram_dout !== 8'hAB) begin
            failures++; $display("FAIL sh_hold ram_wr=%b ram_dout=%h required 0/ab", ram_wr, ram_dout);
        end
        run_access(0, 0, 2'd2, 0, 32'h200, '0, lat, d, bcnt);
        checks++;
        if (d !== ref_load(32'h200, 4, 0)) begin failures++; $display("FAIL sh_readback got %h required %h", d, ref_load(32'h200, 4, 0)); end
    endtask

    task automatic test_contention();
        int k, md1, md2, id;
        logic [31:0] exp_m, exp_i;
        exp_m = ref_load(32'h310, 4, 0);
        exp_i = ref_load(32'h100, 4, 0);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_signed = 1'b0; mem_addr = 32'h310;
        if_req = 1'b1; if_addr = 32'h100;
        k = 0; md1 = 0; md2 = 0; id = 0;
        tick();  // both requests present at this grant edge
        k = 1;
        while (k < 40 && md2 == 0) begin
            if (mem_done) begin if (md1 == 0) md1 = k; else begin md2 = k; mem_req = 1'b0; end end
            if (if_done) begin id = k; if_req = 1'b0; end
            if (md2 == 0) begin tick(); k++; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        checks++;
        if (md1 != 6) begin failures++; $display("FAIL contend_mem_first got %0d required 6", md1); end
        checks++;
        if (id != 12) begin failures++; $display("FAIL contend_if got %0d required 12", id); end
        checks++;
        if (md2 != 18) begin failures++; $display("FAIL contend_mem_second got %0d required 18", md2); end
        checks++;
        if (if_data !== exp_i || mem_rdata !== exp_m) begin
            failures++; $display("FAIL contend_data if=%h mem=%h required %h/%h", if_data, mem_rdata, exp_i, exp_m);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, bcnt, n, bad;
        bit is_if, we, sgn;
        logic [1:0] sz;
        logic [31:0] a, wd, d, exp;
        for (int t = 0; t < 40; t++) begin
            is_if = ($urandom_range(0, 3) == 0);
            we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
            sz    = is_if ? 2'd2 : 2'($urandom_range(0, 3));
            sgn   = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'h1000 + 32'($urandom_range(0, 15));
            wd    = $urandom();
            n     = nbytes(sz);
            exp   = is_if ? ref_load(a, 4, 0) : ref_load(a, n, sgn);
            run_access(is_if, we, sz, sgn, a, wd, lat, d, bcnt);
            checks++;
            if (lat != (we ? n + 1 : n + 2) || bcnt != n) begin
                failures++; $display("FAIL rand_timing t=%0d lat=%0d busy=%0d n=%0d we=%0d", t, lat, bcnt, n, we);
            end
            if (we) begin
                bad = (wl_addr.size() != n);
                for (int i = 0; i < n && !bad; i++)
                    if (wl_addr[i] !== a + 32'(i) || wl_data[i] !== 8'(wd >> (8 * i))) bad = 1;
                for (int i = 0; i < n; i++) refm[a + 32'(i)] = 8'(wd >> (8 * i));
                checks++;
                if (bad) begin failures++; $display("FAIL rand_store t=%0d addr=%h wd=%h n=%0d writes=%0d", t, a, wd, n, wl_addr.size()); end
            end else begin
                checks++;
                if (d !== exp || wl_addr.size() != 0) begin
                    failures++; $display("FAIL rand_load t=%0d addr=%h got %h required %h", t, a, d, exp);
                end
            end
        end
    endtask

    task automatic test_flush();
        int k, ifd, md;
        logic [31:0] exp;
`ifdef MEM_CTRL_FETCH_ABORT_EN
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick();  // cycle E+2
        if_flush = 1'b1; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_signed = 1'b0; mem_addr = 32'h310;
        tick();          // cycle E+3
        if_flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle busy=%b required 0", busy); end
        k = 3; ifd = 0; md = 0;
        while (k < 30 && md == 0) begin
            tick(); k++;
            if (if_done) ifd++;
            if (mem_done) md = k;
        end
        mem_req = 1'b0;
        checks++;
        if (md != 9 || ifd != 0) begin failures++; $display("FAIL flush_abort mem_done at %0d if_done %0d required 9/0", md, ifd); end
        tick();
        if_req = 1'b1; if_flush = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_block busy=%b required 0", busy); end
        if_flush = 1'b0;
        exp = ref_load(32'h100, 4, 0);
        tick(); k = 1; ifd = 0;
        while (k < 20 && ifd == 0) begin if (if_done) ifd = k; else begin tick(); k++; end end
        if_req = 1'b0;
        checks++;
        if (ifd != 6 || if_data !== exp) begin failures++; $display("FAIL flush_refetch at %0d data %h required 6/%h", ifd, if_data, exp); end
        tick();
`else
        exp = ref_load(32'h100, 4, 0);
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        k = 3; ifd = 0; md = 0;
        while (k < 20 && ifd == 0) begin
            if (if_done) ifd = k; else begin tick(); k++; end
        end
        if_req = 1'b0;
        checks++;
        if (ifd != 6 || if_data !== exp) begin failures++; $display("FAIL flush_ignored at %0d data %h required 6/%h", ifd, if_data, exp); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_contention();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
